// File: rtl/audio_pkg.sv
// Shared types and defaults for the I2S DAC playback path.
package audio_pkg;

    // Serializer run state.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } i2s_state_t;

    // Defaults for a 50 MHz system clock:
    // BCLK = 50 MHz / (2 * 8) = 3.125 MHz
    // fs   = 3.125 MHz / 64 = 48.83 kHz
    localparam int DEF_BCLK_HALF_DIV = 8;
    localparam int DEF_SAMPLE_WIDTH  = 16;
    localparam int DEF_SLOT_WIDTH    = 32;

    // BCLK periods in one left+right frame.
    function automatic int frame_bclks(input int slot_width);
        return 2 * slot_width;
    endfunction

endpackage

// File: rtl/audio_bclk_gen.sv
// BCLK divider: toggles bclk every BCLK_HALF_DIV system clocks while enabled.
// It also flags the system clock edge on which bclk will fall.
module audio_bclk_gen #(
    parameter int BCLK_HALF_DIV = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bclk,
    output logic fall
);

    localparam int CW = $clog2(BCLK_HALF_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(BCLK_HALF_DIV - 1);

    logic [CW-1:0] div_cnt;

    // Half-period counter and BCLK toggle. Held at zero/low while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (!en) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign fall = en && (div_cnt == DIV_LAST) && bclk;

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S playback serializer: one-pair holding buffer, run/drain FSM and
// per-slot shift registers driving DACLRCK/DACDAT on BCLK falling edges.
//
// state | meaning
// IDLE  | stopped; BCLK low, LRCK high, data low
// RUN   | streaming frames, loading a new pair at each frame boundary
// DRAIN | stop requested; finish current frame, then IDLE
module audio_i2s_tx
    import audio_pkg::*;
#(
    parameter int BCLK_HALF_DIV = DEF_BCLK_HALF_DIV,
    parameter int SAMPLE_WIDTH  = DEF_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH    = DEF_SLOT_WIDTH
) (
    input  logic                    iclk,
    input  logic                    irst_n,
    input  logic                    ien,
    input  logic                    isample_valid,
    input  logic [SAMPLE_WIDTH-1:0] isample_left,
    input  logic [SAMPLE_WIDTH-1:0] isample_right,
    output logic                    osample_ready,
    output logic                    obclk,
    output logic                    odaclrck,
    output logic                    odacdat,
    output logic                    oframe_start,
    output logic                    ounderrun,
    output logic                    obusy
);

    localparam int FRAME = frame_bclks(SLOT_WIDTH);
    localparam int BW    = $clog2(FRAME);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME - 1);
    localparam logic [BW-1:0] SLOT_B   = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] SW_B     = BW'(SAMPLE_WIDTH);

    i2s_state_t state, state_next;

    logic                    fall_tick;
    logic                    buf_full;
    logic [SAMPLE_WIDTH-1:0] buf_left, buf_right;
    logic [SAMPLE_WIDTH-1:0] sh_left, sh_right;
    logic [BW-1:0]           bit_cnt, bit_next, pos;
    logic                    right_slot, in_window;
    logic                    accept, wrap, stop_now, load;

    audio_bclk_gen #(
        .BCLK_HALF_DIV(BCLK_HALF_DIV)
    ) u_bclk (
        .clk   (iclk),
        .rst_n (irst_n),
        .en    (state != IDLE),
        .bclk  (obclk),
        .fall  (fall_tick)
    );

    assign osample_ready = !buf_full;
    assign accept        = isample_valid && !buf_full;

    // A falling edge at the last bit is the frame boundary; in DRAIN with no
    // renewed run request it ends the stream instead of loading a frame.
    assign wrap     = fall_tick && (bit_cnt == LAST_BIT);
    assign stop_now = wrap && (state == DRAIN) && !ien;
    assign load     = wrap && !stop_now;

    // Bit position that the coming falling edge moves to.
    always_comb begin
        bit_next   = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        right_slot = (bit_next >= SLOT_B);
        pos        = right_slot ? bit_next - SLOT_B : bit_next;
        in_window  = (pos != '0) && (pos <= SW_B);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ien) state_next = RUN;
            RUN:     if (!ien) state_next = DRAIN;
            DRAIN: begin
                if (stop_now)  state_next = IDLE;
                else if (ien)  state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and busy flag.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state <= IDLE;
            obusy <= 1'b0;
        end else begin
            state <= state_next;
            obusy <= (state_next != IDLE);
        end
    end

    // Holding buffer. An accept on the load cycle lands here after the load
    // has already taken the (empty) buffer, so it waits for the next frame.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            buf_full  <= 1'b0;
            buf_left  <= '0;
            buf_right <= '0;
        end else if (accept) begin
            buf_full  <= 1'b1;
            buf_left  <= isample_left;
            buf_right <= isample_right;
        end else if (load) begin
            buf_full  <= 1'b0;
        end
    end

    // Bit counter, frame load and serial output, all on BCLK falling edges.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            bit_cnt      <= LAST_BIT;
            odaclrck     <= 1'b1;
            odacdat      <= 1'b0;
            sh_left      <= '0;
            sh_right     <= '0;
            oframe_start <= 1'b0;
            ounderrun    <= 1'b0;
        end else begin
            oframe_start <= 1'b0;
            ounderrun    <= 1'b0;
            if (stop_now) begin
                bit_cnt  <= LAST_BIT;
                odaclrck <= 1'b1;
                odacdat  <= 1'b0;
            end else if (fall_tick) begin
                bit_cnt  <= bit_next;
                odaclrck <= right_slot;
                if (load) begin
                    sh_left      <= buf_full ? buf_left  : '0;
                    sh_right     <= buf_full ? buf_right : '0;
                    oframe_start <= 1'b1;
                    ounderrun    <= !buf_full;
                    odacdat      <= 1'b0;
                end else if (in_window) begin
                    if (right_slot) begin
                        odacdat  <= sh_right[SAMPLE_WIDTH-1];
                        sh_right <= {sh_right[SAMPLE_WIDTH-2:0], 1'b0};
                    end else begin
                        odacdat  <= sh_left[SAMPLE_WIDTH-1];
                        sh_left  <= {sh_left[SAMPLE_WIDTH-2:0], 1'b0};
                    end
                end else begin
                    odacdat <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Directed + randomized bench for audio_i2s_tx with BCLK_HALF_DIV=2.
module tb_audio_i2s_tx;

    localparam int H = 2;
    localparam logic [63:0] LRCK_PAT = {32'hFFFF_FFFF, 32'h0000_0000};

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        ur;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n, ien, isample_valid;
    logic [15:0] isample_left, isample_right;
    logic        osample_ready, obclk, odaclrck, odacdat, oframe_start, ounderrun, obusy;

    int checks = 0;
    int failures = 0;

    always #10 clk = ~clk;

    audio_i2s_tx #(
        .BCLK_HALF_DIV(H),
        .SAMPLE_WIDTH (16),
        .SLOT_WIDTH   (32)
    ) dut (
        .iclk          (clk),
        .irst_n        (rst_n),
        .ien           (ien),
        .isample_valid (isample_valid),
        .isample_left  (isample_left),
        .isample_right (isample_right),
        .osample_ready (osample_ready),
        .obclk         (obclk),
        .odaclrck      (odaclrck),
        .odacdat       (odacdat),
        .oframe_start  (oframe_start),
        .ounderrun     (ounderrun),
        .obusy         (obusy)
    );

    // Reference model: accepted pairs queue up; each frame load takes the
    // oldest pair accepted strictly before the load edge, otherwise underrun.
    logic [31:0] pair_q[$];
    frame_t      exp_q[$];
    logic        pend_v = 1'b0;
    logic [31:0] pend = '0;
    int          frames_seen = 0, underruns = 0, accepts = 0;
    int          cadence_bad = 0, cyc = 0, last_fall = 0;
    logic        fall_valid = 1'b0, mon_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pair_q.delete();
            exp_q.delete();
            pend_v     = 1'b0;
            fall_valid = 1'b0;
            mon_prev   = 1'b0;
        end else begin
            if (oframe_start) begin
                frames_seen++;
                if (pair_q.size() > 0) begin
                    logic [31:0] p;
                    p = pair_q.pop_front();
                    exp_q.push_back('{p[31:16], p[15:0], 1'b0});
                end else begin
                    exp_q.push_back('{16'h0, 16'h0, 1'b1});
                end
            end
            if (ounderrun) underruns++;
            if (pend_v) pair_q.push_back(pend);
            pend_v = isample_valid && osample_ready;
            pend   = {isample_left, isample_right};
            if (pend_v) accepts++;
            if (!obusy) fall_valid = 1'b0;
            else if (mon_prev && !obclk) begin
                if (fall_valid && (cyc - last_fall != 2 * H)) cadence_bad++;
                last_fall  = cyc;
                fall_valid = 1'b1;
            end
            mon_prev = obclk;
            cyc++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected DACDAT over one frame, bit b of the result = bit position b.
    function automatic logic [63:0] frame_bits(input logic [15:0] l, input logic [15:0] r);
        logic [63:0] v;
        logic [15:0] t;
        v = '0;
        for (int b = 63; b >= 0; b--) begin
            int p;
            p = b % 32;
            t = '0;
            if (p >= 1 && p <= 16) t = ((b < 32) ? l : r) >> (16 - p);
            v = {v[62:0], t[0]};
        end
        return v;
    endfunction

    logic        bclk_prev = 1'b0, bclk_now = 1'b0, last_acc = 1'b0, bp_mode = 1'b0;
    logic [63:0] cap_data, cap_lrck;
    logic        ur_flag, ready_at_start;

    task automatic step();
        last_acc = isample_valid && osample_ready;
        @(posedge clk);
        #1;
        bclk_prev = bclk_now;
        bclk_now  = obclk;
        if (bp_mode && last_acc) begin
            isample_left  = 16'($urandom);
            isample_right = 16'($urandom);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        logic ok;
        ok = 1'b0;
        isample_valid = 1'b1;
        isample_left  = l;
        isample_right = r;
        for (int k = 0; k < 600; k++) begin
            step();
            if (last_acc) begin ok = 1'b1; break; end
        end
        isample_valid = 1'b0;
        chk("push_accepted", 64'(ok), 64'(1));
    endtask

    task automatic wait_frame_start(output int n);
        logic found;
        found = 1'b0;
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            n++;
            if (oframe_start) begin found = 1'b1; break; end
        end
        chk("frame_start_seen", 64'(found), 64'(1));
        ur_flag        = ounderrun;
        ready_at_start = osample_ready;
        cap_data       = 64'(odacdat);
        cap_lrck       = 64'(odaclrck);
    endtask

    task automatic capture(input int from_b, input int to_b);
        logic tmo;
        tmo = 1'b0;
        for (int b = from_b; b <= to_b; b++) begin
            logic found;
            found = 1'b0;
            for (int k = 0; k < 4 * H + 2; k++) begin
                step();
                if (bclk_prev && !bclk_now) begin found = 1'b1; break; end
            end
            if (!found) begin tmo = 1'b1; break; end
            cap_data = cap_data | (64'(odacdat) << b);
            cap_lrck = cap_lrck | (64'(odaclrck) << b);
        end
        chk("bclk_fall_timeout", 64'(tmo), 64'(0));
    endtask

    task automatic check_frame(input string tag);
        frame_t e;
        chk({tag, "_model_frame"}, 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, cap_data, frame_bits(e.l, e.r));
            chk({tag, "_lrck"}, cap_lrck, LRCK_PAT);
            chk({tag, "_underrun"}, 64'(ur_flag), 64'(e.ur));
        end
    endtask

    initial begin
        int c, fb, acc0;
        logic [15:0] sl, sr;

        rst_n = 1'b0; ien = 1'b0; isample_valid = 1'b0;
        isample_left = '0; isample_right = '0;
        step(); step();
        chk("reset_outputs",
            64'({osample_ready, obclk, odaclrck, odacdat, oframe_start, ounderrun, obusy}),
            64'(7'b1010000));
        rst_n = 1'b1;
        step();

        // Basic frame, pair pushed while idle.
        push(16'hA5C3, 16'h0F01);
        chk("ready_low_when_full", 64'(osample_ready), 64'(0));
        ien = 1'b1;
        wait_frame_start(c);
        chk("first_fall_latency", 64'(c), 64'(5));
        capture(1, 63);
        check_frame("basic");
        chk("basic_bits", cap_data, frame_bits(16'hA5C3, 16'h0F01));
        chk("basic_no_underrun", 64'(underruns), 64'(0));
        chk("basic_one_start", 64'(frames_seen), 64'(1));

        // Two more frames with nothing buffered.
        for (int f = 0; f < 2; f++) begin
            wait_frame_start(c);
            chk("underrun_gap", 64'(c), 64'(2 * H));
            chk("underrun_flag", 64'(ur_flag), 64'(1));
            capture(1, 63);
            check_frame("underrun");
            chk("underrun_zero_data", cap_data, 64'(0));
        end
        chk("underrun_count", 64'(underruns), 64'(2));
        chk("cadence_underrun", 64'(cadence_bad), 64'(0));

        // Offer a pair exactly on the frame-load cycle.
        step(); step(); step();
        sl = 16'($urandom); sr = 16'($urandom);
        isample_valid = 1'b1; isample_left = sl; isample_right = sr;
        wait_frame_start(c);
        isample_valid = 1'b0;
        chk("simul_gap", 64'(c), 64'(1));
        chk("simul_underrun", 64'(ur_flag), 64'(1));
        capture(1, 63);
        check_frame("simul_a");
        wait_frame_start(c);
        capture(1, 63);
        check_frame("simul_b");
        chk("simul_pair_next_frame", cap_data, frame_bits(sl, sr));

        // Back-pressure: valid held high for 8 frames.
        bp_mode = 1'b1;
        isample_valid = 1'b1;
        isample_left = 16'($urandom); isample_right = 16'($urandom);
        step(); step();
        acc0 = accepts;
        for (int f = 0; f < 8; f++) begin
            wait_frame_start(c);
            chk("bp_ready_at_start", 64'(ready_at_start), 64'(1));
            capture(1, 63);
            check_frame("bp");
        end
        chk("bp_accepts_per_frame", 64'(accepts - acc0), 64'(8));
        bp_mode = 1'b0;
        isample_valid = 1'b0;

        // Stop at b=5: frame completes, then idle.
        wait_frame_start(c);
        capture(1, 5);
        ien = 1'b0;
        capture(6, 63);
        check_frame("stop");
        fb = frames_seen;
        c = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            c++;
            if (!obusy) break;
        end
        chk("stop_idle_latency", 64'(c), 64'(2 * H));
        chk("stop_idle_outputs",
            64'({obclk, odaclrck, odacdat, oframe_start, ounderrun}), 64'(5'b01000));
        repeat (10) step();
        chk("stop_no_new_frame", 64'(frames_seen), 64'(fb));
        chk("stop_stays_idle", 64'({obclk, odaclrck, obusy}), 64'(3'b010));

        // Re-raise ien while draining: streaming continues without a gap.
        push(16'($urandom), 16'($urandom));
        ien = 1'b1;
        wait_frame_start(c);
        capture(1, 20);
        ien = 1'b0;
        capture(21, 24);
        ien = 1'b1;
        capture(25, 63);
        check_frame("cancel_a");
        wait_frame_start(c);
        chk("cancel_no_gap", 64'(c), 64'(2 * H));
        capture(1, 63);
        check_frame("cancel_b");
        chk("cadence_cancel", 64'(cadence_bad), 64'(0));

        // Reset mid-frame with a full buffer.
        push(16'($urandom), 16'($urandom));
        wait_frame_start(c);
        push(16'($urandom), 16'($urandom));
        capture(1, 10);
        chk("pre_reset_full", 64'(osample_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            64'({osample_ready, obclk, odaclrck, odacdat, oframe_start, ounderrun, obusy}),
            64'(7'b1010000));
        ien = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        ien = 1'b1;
        wait_frame_start(c);
        chk("post_reset_underrun", 64'(ur_flag), 64'(1));
        capture(1, 63);
        check_frame("post_reset");
        ien = 1'b0;
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- I2S playback serializer for the audio codec DAC path.
- Accepts stereo PCM sample pairs over a valid/ready handshake and buffers one pair.
- Generates the codec bit clock (BCLK), DAC left/right clock (DACLRCK) and serial data (DACDAT) from the 50 MHz system clock.
- Sits between the sample source (tone generator/DSP) and the codec pins, alongside the master-clock divider that feeds the codec MCLK.

Parameters:
- BCLK_HALF_DIV, 8, iclk cycles per BCLK half-period (default gives 3.125 MHz BCLK, 48.83 kHz fs); legal range >= 2.
- SAMPLE_WIDTH, 16, bits per channel sample, MSB first; must satisfy SAMPLE_WIDTH <= SLOT_WIDTH-1.
- SLOT_WIDTH, 32, BCLK periods per channel slot; frame length = 2*SLOT_WIDTH.

Ports:
- iclk  input  1  system clock, 50 MHz; all logic on its rising edge.
- irst_n  input  1  asynchronous active-low reset.
- ien  input  1  run request: high starts streaming, low stops at the next frame boundary.
- isample_valid  input  1  sample pair offered.
- isample_left  input  SAMPLE_WIDTH  left sample, two's complement.
- isample_right  input  SAMPLE_WIDTH  right sample, two's complement.
- osample_ready  output  1  holding buffer empty; transfer occurs when valid && ready.
- obclk  output  1  codec BCLK.
- odaclrck  output  1  codec DACLRCK; low = left slot.
- odacdat  output  1  codec DACDAT.
- oframe_start  output  1  one-cycle pulse when a frame is loaded.
- ounderrun  output  1  one-cycle pulse when a frame is loaded with no buffered pair.
- obusy  output  1  state != IDLE.

Behaviour:
- Reset values (async, on irst_n low): state IDLE, holding buffer empty, osample_ready 1, obclk 0, odaclrck 1, odacdat 0, oframe_start 0, ounderrun 0, obusy 0. Divider counter and bit counter are set to 0 and 2*SLOT_WIDTH-1.
- All outputs are registered; there are no combinational paths from inputs to outputs except osample_ready = !buffer_full.
- Handshake: accept on the cycle where isample_valid && osample_ready; buffer_full goes 1 the next cycle. Acceptance is allowed in every state, including IDLE.
- States:
  - IDLE: obclk 0, odaclrck 1, odacdat 0. When ien=1, go to RUN next cycle, with the divider counter at 0 and the bit counter at 2*SLOT_WIDTH-1.
  - RUN: the divider counts 0..BCLK_HALF_DIV-1; at terminal count obclk toggles and the counter wraps to 0.
    - First rising BCLK edge comes BCLK_HALF_DIV cycles after RUN entry; first falling edge comes 2*BCLK_HALF_DIV cycles after entry.
    - On each BCLK falling edge (the same iclk edge that drives obclk 1->0), the bit counter b increments modulo 2*SLOT_WIDTH, and odaclrck and odacdat update on that same edge.
    - odaclrck = (b >= SLOT_WIDTH).
    - With p = b mod SLOT_WIDTH: odacdat = sample[SAMPLE_WIDTH-p] for 1 <= p <= SAMPLE_WIDTH (I2S one-bit delay after the LRCK edge, MSB first); otherwise 0.
  - Frame load at b = 0:
    - If buffer_full: copy the pair into the shift registers, clear buffer_full, pulse oframe_start.
    - Else: load zeros, pulse oframe_start and ounderrun.
    - If acceptance and frame load happen in the same cycle (buffer was empty): the load is an underrun, and the accepted pair is held for the next frame.
  - If ien=0 is sampled in RUN, go to DRAIN.
  - DRAIN: behaves exactly like RUN until the falling edge that would set b back to 0. On that edge, go to IDLE with obclk 0 and odaclrck 1, no frame load and no pulses. If ien returns to 1 during DRAIN, go back to RUN and cancel the stop.
- Buffered data survives stop/start. Reset mid-frame discards the buffer and the shift data immediately.
- Width rules: counters are sized with $clog2 of their range; no truncation of sample data.

Decomposition:
- Package audio_pkg: typedef enum {IDLE, RUN, DRAIN} i2s_state_t, plus shared constants (default SAMPLE_WIDTH, SLOT_WIDTH, codec fs notes).
- One natural sub-module: audio_bclk_gen. It holds the divider counter, obclk and a falling-edge strobe, and is enabled by RUN/DRAIN. The top level keeps the FSM, buffer and shift logic.

Test Plan:
- Reset mid-frame: assert irst_n=0 while b=10 -> all outputs at their reset values within 0 cycles (async), osample_ready=1.
- Basic frame: BCLK_HALF_DIV=2; push L=16'hA5C3, R=16'h0F01 in IDLE, then ien=1 -> first falling edge 4 cycles after RUN entry.
  - odaclrck low for 32 BCLKs, then high for 32.
  - odacdat is 0 at p=0, then 1010010111000011, then zeros; the right slot carries 0000111100000001.
  - One oframe_start pulse, no ounderrun.
- Underrun: run 3 frames with only 1 pair pushed -> frames 2 and 3 carry all-zero data, ounderrun pulses exactly twice, BCLK cadence unbroken.
- Simultaneous accept/load: present valid on exactly the frame-load cycle with the buffer empty -> ounderrun that frame, and the pair appears in the next frame.
- Back-pressure: hold isample_valid high continuously -> exactly one accept per frame, accept occurs 1 cycle after each oframe_start, no pair is lost or duplicated (scoreboard 8 frames).
- Stop/restart: drop ien at b=5 -> completes through b=63, then IDLE with obclk=0 and odaclrck=1. Separately, raise ien again in DRAIN -> no gap, and the next frame starts normally.
